// File: rtl/host_spi_master.sv
// Host-side mode-0 SPI master: shifts one DW-bit frame out MSB first and captures the last RX MISO bits.
// Optional HOST_SPI_READ_DECODE_EN: rx_valid/rx_data only for read frames (op 2'b01).
module host_spi_master #(
  parameter int DW = 16,
  parameter int RX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_start,
  input  logic [DW-1:0] spi_tx_data,
  output logic          spi_complete,
  output logic [RX-1:0] spi_rx_data,
  output logic          spi_rx_valid,
  output logic          spi_sck,
  output logic          spi_csn,
  output logic          spi_mosi,
  input  logic          spi_miso
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] tx_q, tx_d;
  logic [RX-1:0] rx_q, rx_d;
  logic          csn_q, csn_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          complete_q, complete_d;
  logic          rx_valid_q, rx_valid_d;
  logic [RX-1:0] rx_data_q, rx_data_d;
  logic          rx_upd;

`ifdef HOST_SPI_READ_DECODE_EN
  logic rd_q, rd_d;
  assign rx_upd = rd_q;
`else
  assign rx_upd = 1'b1;
`endif

  // Pins are registered from the current state, so they trail it by one
  // cycle; MISO is therefore sampled in SHIFT_LO, the edge that closes
  // the visible high phase of sck.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    csn_d      = 1'b1;
    sck_d      = 1'b0;
    mosi_d     = 1'b0;
    complete_d = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
`ifdef HOST_SPI_READ_DECODE_EN
    rd_d       = rd_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (spi_start) begin
          state_d = SETUP;
          tx_d    = spi_tx_data;
          rx_d    = '0;
          cnt_d   = CW'(DW);
`ifdef HOST_SPI_READ_DECODE_EN
          rd_d    = (spi_tx_data[DW-1:DW-2] == 2'b01);
`endif
        end
      end
      SETUP: begin
        csn_d   = 1'b0;
        mosi_d  = tx_q[DW-1];
        state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        csn_d   = 1'b0;
        sck_d   = 1'b1;
        mosi_d  = mosi_q;
        cnt_d   = cnt_q - CW'(1);
        state_d = SHIFT_LO;
      end
      SHIFT_LO: begin
        csn_d = 1'b0;
        rx_d  = {rx_q[RX-2:0], spi_miso};
        if (cnt_q == '0) begin
          mosi_d  = mosi_q;
          state_d = DONE;
        end else begin
          mosi_d  = tx_q[DW-2];
          tx_d    = {tx_q[DW-2:0], 1'b0};
          state_d = SHIFT_HI;
        end
      end
      DONE: begin
        complete_d = 1'b1;
        if (rx_upd) begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      csn_q      <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      complete_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
`ifdef HOST_SPI_READ_DECODE_EN
      rd_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      csn_q      <= csn_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      complete_q <= complete_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
`ifdef HOST_SPI_READ_DECODE_EN
      rd_q       <= rd_d;
`endif
    end
  end

  assign spi_csn      = csn_q;
  assign spi_sck      = sck_q;
  assign spi_mosi     = mosi_q;
  assign spi_complete = complete_q;
  assign spi_rx_valid = rx_valid_q;
  assign spi_rx_data  = rx_data_q;

endmodule

// File: tb/tb_host_spi_master.sv
// Directed + randomized bench for host_spi_master with a frame-level
// reference model of pin timing, MOSI bits and captured read data.
module tb_host_spi_master;

  logic        clk;
  logic        rst;
  logic        spi_start;
  logic [15:0] spi_tx_data;
  logic        spi_complete;
  logic [7:0]  spi_rx_data;
  logic        spi_rx_valid;
  logic        spi_sck;
  logic        spi_csn;
  logic        spi_mosi;
  logic        spi_miso;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_model;

  host_spi_master #(.DW(16), .RX(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_start    (spi_start),
    .spi_tx_data  (spi_tx_data),
    .spi_complete (spi_complete),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .spi_sck      (spi_sck),
    .spi_csn      (spi_csn),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit updates(input logic [15:0] data);
`ifdef HOST_SPI_READ_DECODE_EN
    return data[15:14] == 2'b01;
`else
    return 1'b1;
`endif
  endfunction

  // Expected {csn,sck,complete,rx_valid} k cycles after the start edge.
  function automatic logic [3:0] ctl_exp(input int k, input bit upd);
    logic csn_e, sck_e, cmp_e;
    csn_e = !(k >= 1 && k <= 33);
    sck_e = (k >= 2 && k <= 32 && (k % 2 == 0));
    cmp_e = (k == 34);
    return {csn_e, sck_e, cmp_e, cmp_e & upd};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("idle_ctl", {spi_csn, spi_sck, spi_complete, spi_rx_valid},
            4'b1000);
      check("idle_mosi", spi_mosi, 0);
    end
  endtask

  // Caller must be at #1 after a posedge; start is sampled on the next edge.
  task automatic run_frame(input logic [15:0] data, input logic [15:0] mbits,
                           input int restart_at, input logic [15:0] alt);
    bit upd;
    upd = updates(data);
    spi_tx_data = data;
    spi_start   = 1'b1;
    @(posedge clk);
    #1;
    spi_start   = 1'b0;
    spi_tx_data = 16'($urandom);
    check("gap_ctl", {spi_csn, spi_sck, spi_complete}, 3'b100);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      if (k == restart_at) begin
        spi_start   = 1'b1;
        spi_tx_data = alt;
      end else begin
        spi_start = 1'b0;
      end
      if ((k % 2 == 1) && k <= 31)
        spi_miso = mbits[15 - (k - 1) / 2];
      check($sformatf("ctl_k%0d", k),
            {spi_csn, spi_sck, spi_complete, spi_rx_valid}, ctl_exp(k, upd));
      if (k == 1)
        check("mosi_setup", spi_mosi, data[15]);
      if (k >= 2 && k <= 32 && (k % 2 == 0))
        check($sformatf("mosi_b%0d", 15 - (k - 2) / 2), spi_mosi,
              data[15 - (k - 2) / 2]);
      if (k == 34) begin
        if (upd) rx_model = mbits[7:0];
        check("done_mosi", spi_mosi, 0);
        check("rx_data", spi_rx_data, rx_model);
      end
    end
    spi_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rx_model = 8'h00;
    check("rst_ctl", {spi_csn, spi_sck, spi_complete, spi_rx_valid}, 4'b1000);
    check("rst_mosi", spi_mosi, 0);
    check("rst_rx_data", spi_rx_data, rx_model);
    rst = 1'b0;
  endtask

  task automatic abort_frame(input logic [15:0] data);
    int ncomp;
    spi_tx_data = data;
    spi_start   = 1'b1;
    @(posedge clk);
    #1;
    spi_start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      spi_miso = 1'($urandom);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_model = 8'h00;
    check("abort_ctl", {spi_csn, spi_sck, spi_complete, spi_rx_valid},
          4'b1000);
    check("abort_mosi", spi_mosi, 0);
    check("abort_rx_data", spi_rx_data, rx_model);
    ncomp = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (spi_complete || !spi_csn) ncomp++;
    end
    check("abort_no_activity", ncomp, 0);
  endtask

  initial begin
    logic [15:0] d;
    rst         = 1'b1;
    spi_start   = 1'b0;
    spi_tx_data = 16'h0000;
    spi_miso    = 1'b0;
    rx_model    = 8'h00;

    do_reset();
    idle(2);

    run_frame(16'hA5C3, 16'($urandom), -1, 16'h0);
    idle(3);

    run_frame(16'h6A00, {8'($urandom), 8'h3C}, -1, 16'h0);
    idle(1);

    run_frame(16'h8123, 16'hFFFF, -1, 16'h0);
    idle(2);

    run_frame(16'h4ABC, 16'($urandom), 5, 16'h5F0F);
    idle(4);

    abort_frame(16'h6F55);
    run_frame(16'h6D2E, 16'($urandom), -1, 16'h0);

    run_frame(16'h5A5A, 16'($urandom), -1, 16'h0);
    run_frame(16'hB00B, 16'($urandom), -1, 16'h0);
    idle(1);

    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      if (i % 2 == 0) d[15:14] = 2'b01;
      run_frame(d, 16'($urandom), -1, 16'h0);
      idle(int'($urandom_range(0, 3)));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
